sensor_hcsr04_emulador: RTL

SENSOR_HCSR04_EMULADOR -- requirements
Module: sensor_hcsr04_emulador

---
 rtl/sensor_hcsr04_emulador.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sensor_hcsr04_emulador.sv
// HC-SR04 ultrasonic sensor emulator: measures the trigger pulse, waits for the
// burst time, then produces an echo whose width encodes the programmed distance.
module sensor_hcsr04_emulador #(
  parameter int CICLOS_US      = 50,
  parameter int TRIGGER_MIN_US = 10,
  parameter int ATRASO_US      = 200,
  parameter int US_POR_CM      = 58,
  parameter int TIMEOUT_US     = 38000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  input  logic       sem_objeto,
  output logic       echo,
  output logic       ocupado,
  output logic       erro_trigger,
  output logic [3:0] db_estado
);

  function automatic longint maxl(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  localparam longint N_TRIG = longint'(TRIGGER_MIN_US) * CICLOS_US;
  localparam longint N_ATR  = longint'(ATRASO_US) * CICLOS_US;
  localparam longint N_CM   = longint'(US_POR_CM) * CICLOS_US;
  localparam longint N_TO   = longint'(TIMEOUT_US) * CICLOS_US;
  localparam longint N_MAX  = maxl(maxl(N_TO, 511 * N_CM), maxl(N_TRIG, N_ATR));
  localparam int     CW     = $clog2(N_MAX + 1);

  localparam logic [CW-1:0] TRIG_LIM = CW'(N_TRIG);
  localparam logic [CW-1:0] ATR_LAST = CW'(N_ATR - 1);
  localparam logic [CW-1:0] K_CM     = CW'(N_CM);
  localparam logic [CW-1:0] W_TO     = CW'(N_TO);

  typedef enum logic [3:0] {
    INICIAL = 4'b0000,
    MEDE    = 4'b0001,
    ATRASO  = 4'b0010,
    GERA    = 4'b0011,
    FINAL   = 4'b1111
  } estado_t;

  estado_t       estado, prox;
  logic [CW-1:0] cnt, cnt_prox, largura;
  logic [8:0]    dist_r, d_ef;
  logic          sem_r, trig_r, armado, erro_r, erro_prox, lat, borda;

  // armado blocks a trigger held high through reset from counting as an edge
  assign borda   = trigger & ~trig_r & armado;
  assign d_ef    = (dist_r == 9'd0) ? 9'd1 : dist_r;
  assign largura = sem_r ? W_TO : CW'(d_ef) * K_CM;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
      cnt    <= '0;
      trig_r <= 1'b0;
      armado <= 1'b0;
      dist_r <= '0;
      sem_r  <= 1'b0;
      erro_r <= 1'b0;
    end else begin
      estado <= prox;
      cnt    <= cnt_prox;
      trig_r <= trigger;
      armado <= armado | ~trigger;
      erro_r <= erro_prox;
      if (lat) begin
        dist_r <= distancia;
        sem_r  <= sem_objeto;
      end
    end
  end

  always_comb begin
    prox      = estado;
    cnt_prox  = cnt;
    lat       = 1'b0;
    erro_prox = 1'b0;
    case (estado)
      INICIAL: if (borda) begin
        prox     = MEDE;
        cnt_prox = CW'(1);
      end
      MEDE: begin
        if (trigger) begin
          if (cnt != '1) cnt_prox = cnt + 1'b1;
        end else if (cnt >= TRIG_LIM) begin
          prox     = ATRASO;
          cnt_prox = '0;
          lat      = 1'b1;
        end else begin
          prox      = INICIAL;
          cnt_prox  = '0;
          erro_prox = 1'b1;
        end
      end
      ATRASO: begin
        if (cnt == ATR_LAST) begin
          prox     = GERA;
          cnt_prox = '0;
        end else cnt_prox = cnt + 1'b1;
      end
      GERA: begin
        if (cnt == largura - 1'b1) begin
          prox     = FINAL;
          cnt_prox = '0;
        end else cnt_prox = cnt + 1'b1;
      end
      FINAL: begin
        prox     = INICIAL;
        cnt_prox = '0;
      end
      default: begin
        prox     = INICIAL;
        cnt_prox = '0;
      end
    endcase
  end

  // erro_trigger comes from a flop set on the rejecting transition
  always_comb begin
    echo         = (estado == GERA);
    ocupado      = (estado != INICIAL);
    erro_trigger = erro_r;
    case (estado)
      INICIAL: db_estado = 4'b0000;
      MEDE:    db_estado = 4'b0001;
      ATRASO:  db_estado = 4'b0010;
      GERA:    db_estado = 4'b0011;
      FINAL:   db_estado = 4'b1111;
      default: db_estado = 4'b1110;
    endcase
  end

endmodule
